// File: rtl/instruction_issuer.sv
// Program sequencer: loadable 2**PC_W-word buffer issued word-by-word to the decoder over valid/ready.
// Optional ISSUER_LOOP_EN: the program repeats from address 0 until stop instead of ending at the last word.
module instruction_issuer #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [PC_W-1:0]    wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic [PC_W:0]      prog_len,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        ISSUE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int DEPTH = 2 ** PC_W;
    localparam logic [PC_W:0]   MAX_LEN = {1'b1, {PC_W{1'b0}}};
    localparam logic [PC_W:0]   LEN_ONE = 1;
    localparam logic [PC_W-1:0] PC_ONE  = 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W:0]      len_q, len_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_word;
    logic               handshake;

    // Buffer is deliberately not reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign last_word = ({1'b0, pc_q} == (len_q - LEN_ONE));
    assign handshake = valid_q && instr_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
                    if (prog_len != '0) begin
                        pc_d    = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (stop) begin
                    state_d = DONE;
                end else begin
                    instr_d = mem_q[pc_q];
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // stop wins over advancing, but a same-cycle handshake still counts as accepted
                if (handshake) begin
                    valid_d = 1'b0;
                    if (stop) begin
                        state_d = DONE;
                    end else if (last_word) begin
`ifdef ISSUER_LOOP_EN
                        pc_d    = '0;
                        state_d = FETCH;
`else
                        state_d = DONE;
`endif
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = FETCH;
                    end
                end else if (stop) begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == FETCH) || (state_d == ISSUE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state       = state_q;

endmodule

// File: tb/tb_instruction_issuer.sv
// Scoreboarded bench for instruction_issuer: expected words are queued at start and popped on each handshake.
// Build with ISSUER_LOOP_EN defined to exercise the repeating-program variant instead of the single-run tests.
module tb_instruction_issuer;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 11;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               wr_en;
    logic [PC_W-1:0]    wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic               start;
    logic               stop;
    logic [PC_W:0]      prog_len;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               instr_ready;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic               done;
    logic [1:0]         state;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } exp_t;

    exp_t               exp_q [$];
    logic [INSTR_W-1:0] tb_mem [16];
    int checks      = 0;
    int errors      = 0;
    int hs_count    = 0;
    int valid_cycles = 0;
    int done_pulses = 0;
    int hold_cycles = 0;
    int cyc;

    instruction_issuer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .stop        (stop),
        .prog_len    (prog_len),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadWord(input int addr, input logic [INSTR_W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = PC_W'(addr);
        wr_data = data;
        tb_mem[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Monitor: a handshake is pending when valid and ready are both high between edges.
    always @(negedge clk) begin
        if (reset_n) begin
            if (instr_valid) valid_cycles++;
            if (done) done_pulses++;
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("instr", 32'(instruction), 32'(e.instr));
                    checkOutput("pc_at_issue", 32'(pc), 32'(e.pc));
                end
                hs_count++;
            end else if (instr_valid && exp_q.size() > 0) begin
                checkOutput("hold_instr", 32'(instruction), 32'(exp_q[0].instr));
                hold_cycles++;
            end
        end
    end

    // Starts a run and steps it until done; stall/stop targets are word indices in issue order.
    task automatic applyStimulus(input int len, input int stop_idx, input logic stop_ready,
                                 input int stall_idx, input int stall_len, input bit stray_write,
                                 output int cycles);
        int eff;
        int n_exp;
        int stalled;
        bit stop_sent;
        eff   = (len > 16) ? 16 : len;
        n_exp = (stop_idx < 0) ? eff : (stop_ready ? stop_idx + 1 : stop_idx);
        for (int i = 0; i < n_exp; i++) begin
            exp_t e;
            e.instr = tb_mem[i % eff];
            e.pc    = PC_W'(i % eff);
            exp_q.push_back(e);
        end
        hs_count = 0; valid_cycles = 0; done_pulses = 0; hold_cycles = 0;
        stalled = 0; stop_sent = 1'b0; cycles = 0;
        prog_len    = (PC_W+1)'(len);
        start       = 1'b1;
        instr_ready = 1'b1;
        while (cycles < 300) begin
            tick();
            cycles++;
            start = 1'b0; stop = 1'b0; wr_en = 1'b0; instr_ready = 1'b1;
            if (done) break;
            if (stray_write && cycles == 3) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = 11'h7FF;
            end
            if (instr_valid && hs_count == stall_idx && stalled < stall_len) begin
                instr_ready = 1'b0;
                stalled++;
            end
            if (instr_valid && hs_count == stop_idx && !stop_sent) begin
                stop = 1'b1;
                instr_ready = stop_ready;
                stop_sent = 1'b1;
            end
        end
        checkOutput("run_finished", 32'(done), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; prog_len = '0; instr_ready = 1'b0;
        #12;
        checkOutput("rst_instruction", 32'(instruction), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_state", 32'(state), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        loadWord(0, 11'b001_0010_0101);
        loadWord(1, 11'b010_0100_0011);
        loadWord(2, 11'b100_0001_1110);
        loadWord(3, 11'b101_0011_0110);
        loadWord(4, 11'b110_1111_0001);
        loadWord(5, 11'b111_0100_0000);
        loadWord(6, 11'b000_1010_0100);
        for (int i = 7; i < 16; i++) loadWord(i, INSTR_W'(i * 37 + 5));

`ifndef ISSUER_LOOP_EN
        // Straight run of seven words
        applyStimulus(7, -1, 1'b0, -1, 0, 1'b0, cyc);
        checkOutput("t1_latency", 32'(cyc), 32'd15);
        checkOutput("t1_done_state", 32'(state), 32'd3);
        checkOutput("t1_busy_in_done", 32'(busy), 32'd0);
        checkOutput("t1_last_pc", 32'(pc), 32'd6);
        tick();
        checkOutput("t1_idle", 32'(state), 32'd0);
        checkOutput("t1_done_pulses", 32'(done_pulses), 32'd1);
        checkOutput("t1_valid_cycles", 32'(valid_cycles), 32'd7);
        checkOutput("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t1_instr_kept", 32'(instruction), 32'(tb_mem[6]));

        // Back-pressure on word 2
        applyStimulus(7, -1, 1'b0, 2, 3, 1'b0, cyc);
        checkOutput("t2_latency", 32'(cyc), 32'd18);
        tick();
        checkOutput("t2_hold_cycles", 32'(hold_cycles), 32'd3);
        checkOutput("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t2_done_pulses", 32'(done_pulses), 32'd1);

        // Zero length and oversized length
        applyStimulus(0, -1, 1'b0, -1, 0, 1'b0, cyc);
        checkOutput("t3_zero_latency", 32'(cyc), 32'd1);
        checkOutput("t3_zero_state", 32'(state), 32'd3);
        tick();
        checkOutput("t3_zero_idle", 32'(state), 32'd0);
        checkOutput("t3_zero_valid", 32'(valid_cycles), 32'd0);
        checkOutput("t3_zero_done", 32'(done_pulses), 32'd1);
        applyStimulus(20, -1, 1'b0, -1, 0, 1'b0, cyc);
        checkOutput("t3_big_latency", 32'(cyc), 32'd33);
        checkOutput("t3_big_pc", 32'(pc), 32'd15);
        tick();
        checkOutput("t3_big_words", 32'(hs_count), 32'd16);
        checkOutput("t3_big_queue", 32'(exp_q.size()), 32'd0);

        // Stop on word 3, first dropped, then accepted in the same cycle
        applyStimulus(7, 3, 1'b0, -1, 0, 1'b0, cyc);
        checkOutput("t4_drop_pc", 32'(pc), 32'd3);
        checkOutput("t4_drop_valid", 32'(instr_valid), 32'd0);
        tick();
        checkOutput("t4_drop_done", 32'(done_pulses), 32'd1);
        checkOutput("t4_drop_words", 32'(hs_count), 32'd3);
        checkOutput("t4_drop_queue", 32'(exp_q.size()), 32'd0);
        applyStimulus(7, 3, 1'b1, -1, 0, 1'b0, cyc);
        checkOutput("t4_acc_pc", 32'(pc), 32'd3);
        tick();
        checkOutput("t4_acc_words", 32'(hs_count), 32'd4);
        checkOutput("t4_acc_queue", 32'(exp_q.size()), 32'd0);
        checkOutput("t4_acc_done", 32'(done_pulses), 32'd1);

        // Write attempted mid-run must not land; rerun of one word checks address 0
        applyStimulus(7, -1, 1'b0, -1, 0, 1'b1, cyc);
        tick();
        applyStimulus(1, -1, 1'b0, -1, 0, 1'b0, cyc);
        tick();
        checkOutput("t5_rerun_queue", 32'(exp_q.size()), 32'd0);
        checkOutput("t5_rerun_instr", 32'(instruction), 32'(tb_mem[0]));
`else
        // Repeating program of three words, stopped on the eighth presentation
        applyStimulus(3, 7, 1'b0, -1, 0, 1'b0, cyc);
        checkOutput("t6_stop_pc", 32'(pc), 32'd1);
        tick();
        checkOutput("t6_words", 32'(hs_count), 32'd7);
        checkOutput("t6_queue", 32'(exp_q.size()), 32'd0);
        checkOutput("t6_done", 32'(done_pulses), 32'd1);
        checkOutput("t6_idle", 32'(state), 32'd0);
`endif

        // Asynchronous reset while a word is waiting in ISSUE
        prog_len = 5'd7; start = 1'b1; instr_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        checkOutput("t5_pre_valid", 32'(instr_valid), 32'd1);
        done_pulses = 0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_instruction", 32'(instruction), 32'd0);
        checkOutput("t5_rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("t5_rst_pc", 32'(pc), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_done", 32'(done), 32'd0);
        checkOutput("t5_rst_state", 32'(state), 32'd0);
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("t5_no_done_pulse", 32'(done_pulses), 32'd0);
        checkOutput("t5_post_state", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
